enemy_fleet_ctrl: RTL and testbench

ENEMY_FLEET_CTRL -- requirements
Module: enemy_fleet_ctrl

---
 rtl/enemy_fleet_ctrl.sv | 154 +++++++++++++++
 tb/tb_enemy_fleet_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_fleet_ctrl.sv
// -----------------------------------------------------------------------------
// enemy_fleet_ctrl
// Moves a fleet of enemy columns across the screen. It steps the fleet
// horizontally once every FRAME_DIV frame ticks. When the outermost live column
// would leave the screen, the fleet drops one row and reverses direction.
// When the fleet would drop past the landing row, it lands instead.
//
// Ports
//   Clk               sole clock, rising edge
//   Reset_n           asynchronous active-low reset
//   frame_tick        one-Clk pulse per video frame
//   start             one-Clk pulse launching a wave (IDLE/LANDED only)
//   alive_cols        bit i high while column i has a live enemy
//   fleet_x, fleet_y  fleet origin for the sprite blocks
//   enemy_direction_X 0 = moving left, 1 = moving right
//   enemy_direction_Y one-Clk pulse on the cycle a drop is applied
//   fleet_landed      level, high while LANDED
//   fleet_cleared     one-Clk pulse when the wave is wiped out
//   busy              high in MOVE_RIGHT, MOVE_LEFT or DROP
// -----------------------------------------------------------------------------
module enemy_fleet_ctrl #(
   parameter int unsigned NUM_COLS  = 8,
   parameter int unsigned COL_PITCH = 60,
   parameter int unsigned ENEMY_W   = 50,
   parameter int unsigned START_X   = 20,
   parameter int unsigned START_Y   = 40,
   parameter int unsigned STEP_X    = 2,
   parameter int unsigned STEP_Y    = 16,
   parameter int unsigned FRAME_DIV = 4,
   parameter int unsigned X_MAX     = 639,
   parameter int unsigned Y_LIMIT   = 400
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                frame_tick,
   input  logic                start,
   input  logic [NUM_COLS-1:0] alive_cols,
   output logic [9:0]          fleet_x,
   output logic [9:0]          fleet_y,
   output logic                enemy_direction_X,
   output logic                enemy_direction_Y,
   output logic                fleet_landed,
   output logic                fleet_cleared,
   output logic                busy
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_MOVE_RIGHT = 3'd1;
   localparam logic [2:0] S_MOVE_LEFT  = 3'd2;
   localparam logic [2:0] S_DROP       = 3'd3;
   localparam logic [2:0] S_LANDED     = 3'd4;

   localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);
   localparam logic [10:0] W_M1     = 11'(ENEMY_W - 1);
   localparam logic [10:0] STEPX11  = 11'(STEP_X);
   localparam logic [10:0] STEPY11  = 11'(STEP_Y);
   localparam logic [10:0] XMAX11   = 11'(X_MAX);
   localparam logic [10:0] YLIM11   = 11'(Y_LIMIT);

   logic [2:0]  state;
   logic [7:0]  div;
   logic [10:0] l_off, r_off;
   logic [10:0] left_edge, right_edge;
   logic        move_tick, can_right, can_left, will_land, none_alive;

   // Offsets of the lowest (L) and highest (R) live columns from the origin.
   // The upward scan leaves R in r_off; the downward scan leaves L in l_off.
   always_comb begin
      l_off = '0;
      r_off = '0;
      for (int unsigned i = 0; i < NUM_COLS; i++)
         if (alive_cols[i]) r_off = 11'(i * COL_PITCH);
      for (int unsigned i = NUM_COLS; i > 0; i--)
         if (alive_cols[i-1]) l_off = 11'((i - 1) * COL_PITCH);
   end

   assign right_edge = {1'b0, fleet_x} + r_off + W_M1;
   assign left_edge  = {1'b0, fleet_x} + l_off;
   assign can_right  = (right_edge + STEPX11) <= XMAX11;
   assign can_left   = left_edge >= STEPX11;
   assign will_land  = ({1'b0, fleet_y} + STEPY11) >= YLIM11;
   assign move_tick  = frame_tick && (div == DIV_LAST);
   assign none_alive = (alive_cols == '0);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state             <= S_IDLE;
         div               <= '0;
         fleet_x           <= 10'(START_X);
         fleet_y           <= 10'(START_Y);
         enemy_direction_X <= 1'b1;
         enemy_direction_Y <= 1'b0;
         fleet_landed      <= 1'b0;
         fleet_cleared     <= 1'b0;
         busy              <= 1'b0;
      end else begin
         enemy_direction_Y <= 1'b0;
         fleet_cleared     <= 1'b0;
         case (state)
            S_IDLE, S_LANDED: begin
               // A coincident frame_tick is dropped: the divider restarts at 0.
               if (start) begin
                  state             <= S_MOVE_RIGHT;
                  div               <= '0;
                  fleet_x           <= 10'(START_X);
                  fleet_y           <= 10'(START_Y);
                  enemy_direction_X <= 1'b1;
                  fleet_landed      <= 1'b0;
                  busy              <= 1'b1;
               end
            end
            S_MOVE_RIGHT, S_MOVE_LEFT: begin
               if (none_alive) begin
                  state         <= S_IDLE;
                  busy          <= 1'b0;
                  fleet_cleared <= 1'b1;
               end else if (move_tick) begin
                  div <= '0;
                  if (state == S_MOVE_RIGHT) begin
                     if (can_right) fleet_x <= fleet_x + 10'(STEP_X);
                     else           state   <= S_DROP;
                  end else begin
                     if (can_left)  fleet_x <= fleet_x - 10'(STEP_X);
                     else           state   <= S_DROP;
                  end
               end else if (frame_tick) begin
                  div <= div + 8'd1;
               end
            end
            S_DROP: begin
               if (none_alive) begin
                  state         <= S_IDLE;
                  busy          <= 1'b0;
                  fleet_cleared <= 1'b1;
               end else if (will_land) begin
                  state        <= S_LANDED;
                  busy         <= 1'b0;
                  fleet_landed <= 1'b1;
               end else begin
                  fleet_y           <= fleet_y + 10'(STEP_Y);
                  enemy_direction_Y <= 1'b1;
                  enemy_direction_X <= ~enemy_direction_X;
                  state             <= enemy_direction_X ? S_MOVE_LEFT : S_MOVE_RIGHT;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// -----------------------------------------------------------------------------
// tb_enemy_fleet_ctrl
// Directed bench for enemy_fleet_ctrl with default parameters. Inputs are
// driven and outputs are sampled on the falling edge of Clk.
// -----------------------------------------------------------------------------
module tb_enemy_fleet_ctrl;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       frame_tick;
   logic       start;
   logic [7:0] alive_cols;
   logic [9:0] fleet_x, fleet_y;
   logic       enemy_direction_X, enemy_direction_Y;
   logic       fleet_landed, fleet_cleared, busy;

   int checks   = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   enemy_fleet_ctrl dut (
      .Clk               (Clk),
      .Reset_n           (Reset_n),
      .frame_tick        (frame_tick),
      .start             (start),
      .alive_cols        (alive_cols),
      .fleet_x           (fleet_x),
      .fleet_y           (fleet_y),
      .enemy_direction_X (enemy_direction_X),
      .enemy_direction_Y (enemy_direction_Y),
      .fleet_landed      (fleet_landed),
      .fleet_cleared     (fleet_cleared),
      .busy              (busy)
   );

   // Packed view {x, y, dirX, dirY, landed, cleared, busy}.
   function automatic logic [24:0] outs();
      return {fleet_x, fleet_y, enemy_direction_X, enemy_direction_Y,
              fleet_landed, fleet_cleared, busy};
   endfunction

   task automatic tick();
      @(negedge Clk) frame_tick = 1'b1;
      @(negedge Clk) frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_start();
      @(negedge Clk) start = 1'b1;
      @(negedge Clk) start = 1'b0;
   endtask

   localparam logic [24:0] RESET_OUTS = {10'd20, 10'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic test_reset();
      Reset_n = 1'b0; start = 1'b0; frame_tick = 1'b0; alive_cols = 8'hFF;
      repeat (3) @(negedge Clk);
      checks++;
      if (outs() !== RESET_OUTS) begin
         failures++;
         $display("FAIL reset_values got=%h exp=%h", outs(), RESET_OUTS);
      end
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_idle_ignore();
      ticks(6);
      checks++;
      if (outs() !== RESET_OUTS) begin
         failures++;
         $display("FAIL idle_ticks_ignored got=%h exp=%h", outs(), RESET_OUTS);
      end
   endtask

   task automatic test_first_move();
      pulse_start();
      checks++;
      if ({fleet_x, busy, enemy_direction_X} !== {10'd20, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL start_load got x=%0d busy=%b dirx=%b exp x=20 busy=1 dirx=1",
                  fleet_x, busy, enemy_direction_X);
      end
      ticks(3);
      checks++;
      if (fleet_x !== 10'd20) begin
         failures++;
         $display("FAIL three_ticks_no_move got x=%0d exp 20", fleet_x);
      end
      tick();
      checks++;
      if ({fleet_x, fleet_y, busy} !== {10'd22, 10'd40, 1'b1}) begin
         failures++;
         $display("FAIL fourth_tick_move got x=%0d y=%0d busy=%b exp x=22 y=40 busy=1",
                  fleet_x, fleet_y, busy);
      end
   endtask

   task automatic test_right_edge();
      ticks(296);
      checks++;
      if ({fleet_x, enemy_direction_X, busy} !== {10'd170, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL right_300_ticks got x=%0d dirx=%b busy=%b exp x=170 dirx=1 busy=1",
                  fleet_x, enemy_direction_X, busy);
      end
      ticks(3);
      @(negedge Clk) frame_tick = 1'b1;
      @(negedge Clk) frame_tick = 1'b0;
      // Now in DROP: position not yet touched.
      checks++;
      if ({fleet_x, fleet_y, enemy_direction_Y, busy} !== {10'd170, 10'd40, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL right_drop_enter got x=%0d y=%0d diry=%b busy=%b exp x=170 y=40 diry=0 busy=1",
                  fleet_x, fleet_y, enemy_direction_Y, busy);
      end
      @(negedge Clk);
      checks++;
      if ({fleet_x, fleet_y, enemy_direction_X, enemy_direction_Y} !== {10'd170, 10'd56, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL right_drop_apply got x=%0d y=%0d dirx=%b diry=%b exp x=170 y=56 dirx=0 diry=1",
                  fleet_x, fleet_y, enemy_direction_X, enemy_direction_Y);
      end
      @(negedge Clk);
      checks++;
      if (enemy_direction_Y !== 1'b0) begin
         failures++;
         $display("FAIL diry_one_cycle got diry=%b exp 0", enemy_direction_Y);
      end
   endtask

   task automatic test_left_edge();
      // Only column 0 alive: left edge equals fleet_x.
      alive_cols = 8'h01;
      ticks(340);
      checks++;
      if ({fleet_x, enemy_direction_X, busy} !== {10'd0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL left_reach_zero got x=%0d dirx=%b busy=%b exp x=0 dirx=0 busy=1",
                  fleet_x, enemy_direction_X, busy);
      end
      ticks(4);
      @(negedge Clk);
      checks++;
      if ({fleet_x, fleet_y, enemy_direction_X, enemy_direction_Y} !== {10'd0, 10'd72, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL left_drop got x=%0d y=%0d dirx=%b diry=%b exp x=0 y=72 dirx=1 diry=1",
                  fleet_x, fleet_y, enemy_direction_X, enemy_direction_Y);
      end
   endtask

   task automatic test_start_ignored_and_clear();
      ticks(2);
      pulse_start();
      ticks(2);
      checks++;
      if ({fleet_x, fleet_y} !== {10'd2, 10'd72}) begin
         failures++;
         $display("FAIL start_ignored_in_move got x=%0d y=%0d exp x=2 y=72", fleet_x, fleet_y);
      end
      ticks(2);
      @(negedge Clk) alive_cols = 8'h00;
      @(negedge Clk);
      checks++;
      if ({fleet_x, fleet_cleared, busy} !== {10'd2, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL cleared_pulse got x=%0d cleared=%b busy=%b exp x=2 cleared=1 busy=0",
                  fleet_x, fleet_cleared, busy);
      end
      @(negedge Clk);
      checks++;
      if (fleet_cleared !== 1'b0) begin
         failures++;
         $display("FAIL cleared_one_cycle got cleared=%b exp 0", fleet_cleared);
      end
      ticks(8);
      checks++;
      if ({fleet_x, fleet_y, busy} !== {10'd2, 10'd72, 1'b0}) begin
         failures++;
         $display("FAIL cleared_no_move got x=%0d y=%0d busy=%b exp x=2 y=72 busy=0",
                  fleet_x, fleet_y, busy);
      end
      alive_cols = 8'hFF;
   endtask

   task automatic test_start_with_tick();
      @(negedge Clk) begin start = 1'b1; frame_tick = 1'b1; end
      @(negedge Clk) begin start = 1'b0; frame_tick = 1'b0; end
      ticks(3);
      checks++;
      if ({fleet_x, fleet_y, busy} !== {10'd20, 10'd40, 1'b1}) begin
         failures++;
         $display("FAIL start_tick_not_counted got x=%0d y=%0d busy=%b exp x=20 y=40 busy=1",
                  fleet_x, fleet_y, busy);
      end
      tick();
      checks++;
      if (fleet_x !== 10'd22) begin
         failures++;
         $display("FAIL start_tick_move_after_4 got x=%0d exp 22", fleet_x);
      end
   endtask

   task automatic test_landing();
      int n = 0;
      while (!fleet_landed && n < 9000) begin
         tick();
         n++;
      end
      checks++;
      if (fleet_landed !== 1'b1) begin
         failures++;
         $display("FAIL landing_timeout got landed=%b after %0d ticks exp 1", fleet_landed, n);
      end
      checks++;
      if ({fleet_x, fleet_y, enemy_direction_X, busy} !== {10'd170, 10'd392, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL landed_state got x=%0d y=%0d dirx=%b busy=%b exp x=170 y=392 dirx=1 busy=0",
                  fleet_x, fleet_y, enemy_direction_X, busy);
      end
      ticks(4);
      checks++;
      if ({fleet_y, fleet_landed} !== {10'd392, 1'b1}) begin
         failures++;
         $display("FAIL landed_holds got y=%0d landed=%b exp y=392 landed=1", fleet_y, fleet_landed);
      end
      pulse_start();
      checks++;
      if (outs() !== {10'd20, 10'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL restart_from_landed got=%h exp=%h", outs(),
                  {10'd20, 10'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      end
   endtask

   task automatic test_reset_in_drop();
      ticks(303);
      @(negedge Clk) frame_tick = 1'b1;
      @(negedge Clk) frame_tick = 1'b0;
      checks++;
      if ({fleet_x, busy} !== {10'd170, 1'b1}) begin
         failures++;
         $display("FAIL pre_reset_drop got x=%0d busy=%b exp x=170 busy=1", fleet_x, busy);
      end
      Reset_n = 1'b0;
      #1;
      checks++;
      if (outs() !== RESET_OUTS) begin
         failures++;
         $display("FAIL async_reset_in_drop got=%h exp=%h", outs(), RESET_OUTS);
      end
      @(negedge Clk) Reset_n = 1'b1;
      ticks(8);
      checks++;
      if (outs() !== RESET_OUTS) begin
         failures++;
         $display("FAIL no_resume_after_reset got=%h exp=%h", outs(), RESET_OUTS);
      end
   endtask

   initial begin
      test_reset();
      test_idle_ignore();
      test_first_move();
      test_right_edge();
      test_left_edge();
      test_start_ignored_and_clear();
      test_start_with_tick();
      test_landing();
      test_reset_in_drop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
